// File: rtl/snake_pkg.sv
// Shared definitions for the snake game-step engine: cell codes, directions,
// FSM states and per-direction address arithmetic on the 16x16 board.
package snake_pkg;

    localparam int         GRID_W     = 16;
    localparam logic [3:0] GRID_MAX   = 4'(GRID_W - 1);
    localparam logic [3:0] CELL_EMPTY = 4'd14;
    localparam logic [3:0] CELL_FOOD  = 4'd15;
    localparam logic [3:0] HEAD_BASE  = 4'd4;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [3:0] {
        ST_INIT, ST_IDLE, ST_CHK, ST_EVAL, ST_WR_HEAD,
        ST_RD_TAIL, ST_TAIL_CLR, ST_FOOD_RD, ST_FOOD_EVAL, ST_OVER
    } state_e;

    function automatic logic [7:0] dir_offset(dir_e d);
        case (d)
            DIR_UP:   return 8'(-GRID_W);
            DIR_DOWN: return 8'(GRID_W);
            DIR_LEFT: return 8'hFF;
            default:  return 8'd1;
        endcase
    endfunction

    // Up/down and left/right differ only in bit 0.
    function automatic dir_e opposite_dir(dir_e d);
        return dir_e'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/snake_mover_if.sv
// Board RAM port: the mover drives address/write, the RAM returns registered read data.
interface snake_mover_if;
    logic [7:0] ram_addr;
    logic       ram_we;
    logic [3:0] ram_wdata;
    logic [3:0] ram_rdata;

    modport master (output ram_addr, output ram_we, output ram_wdata, input ram_rdata);
    modport slave  (input ram_addr, input ram_we, input ram_wdata, output ram_rdata);
endinterface

// File: rtl/snake_next_cell.sv
// Neighbour cell address in a given direction, flagging moves that leave the board.
module snake_next_cell
    import snake_pkg::*;
(
    input  logic [7:0] addr,
    input  dir_e       dir,
    output logic [7:0] next_addr,
    output logic       edge_hit
);
    logic [3:0] row;
    logic [3:0] col;

    assign row       = addr[7:4];
    assign col       = addr[3:0];
    assign next_addr = addr + dir_offset(dir);

    always_comb begin
        edge_hit = 1'b0;
        case (dir)
            DIR_UP:    edge_hit = (row == 4'd0);
            DIR_DOWN:  edge_hit = (row == GRID_MAX);
            DIR_LEFT:  edge_hit = (col == 4'd0);
            default:   edge_hit = (col == GRID_MAX);
        endcase
    end
endmodule

// File: rtl/snake_mover.sv
// Game-step engine: sole writer of the board RAM. Each tick moves the head,
// detects collisions, then clears the tail or grows and places new food.
module snake_mover
    import snake_pkg::*;
#(
    parameter logic [7:0] INIT_HEAD = 8'd136,
    parameter logic [7:0] INIT_TAIL = 8'd152,
    parameter logic [1:0] INIT_DIR  = 2'd2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          dir_valid,
    input  logic [1:0]    dir_req,
    input  logic [7:0]    rand_addr,
    snake_mover_if.master ram,
    output logic          busy,
    output logic          game_over,
    output logic [7:0]    score
);
    state_e     state_q, state_d;
    logic [7:0] head_q, head_d, tail_q, tail_d;
    logic [7:0] food_try_q, food_try_d, score_q, score_d;
    dir_e       heading_q, heading_d, pend_q, pend_d;
    logic       grow_q, grow_d;

    logic [7:0] head_next, tail_next;
    logic       head_edge, tail_edge;
    dir_e       tail_dir, req_dir;

    assign tail_dir = dir_e'(ram.ram_rdata[1:0]);
    assign req_dir  = dir_e'(dir_req);

    snake_next_cell u_head_next (
        .addr(head_q), .dir(heading_q), .next_addr(head_next), .edge_hit(head_edge)
    );
    snake_next_cell u_tail_next (
        .addr(tail_q), .dir(tail_dir), .next_addr(tail_next), .edge_hit(tail_edge)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_INIT;
            head_q     <= INIT_HEAD;
            tail_q     <= INIT_TAIL;
            heading_q  <= dir_e'(INIT_DIR);
            pend_q     <= dir_e'(INIT_DIR);
            grow_q     <= 1'b0;
            food_try_q <= '0;
            score_q    <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            heading_q  <= heading_d;
            pend_q     <= pend_d;
            grow_q     <= grow_d;
            food_try_q <= food_try_d;
            score_q    <= score_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        head_d        = head_q;
        tail_d        = tail_q;
        heading_d     = heading_q;
        pend_d        = pend_q;
        grow_d        = grow_q;
        food_try_d    = food_try_q;
        score_d       = score_q;
        ram.ram_addr  = '0;
        ram.ram_we    = 1'b0;
        ram.ram_wdata = CELL_EMPTY;

        if (dir_valid && req_dir != opposite_dir(heading_q))
            pend_d = req_dir;

        case (state_q)
            ST_INIT: state_d = ST_FOOD_RD;
            ST_IDLE: if (tick) begin
                heading_d = pend_q;
                state_d   = ST_CHK;
            end
            ST_CHK: begin
                ram.ram_addr = head_next;
                state_d      = ST_EVAL;
            end
            ST_EVAL: begin
                // Anything but empty or food (incl. reserved codes and the tail) is fatal.
                if (head_edge || ram.ram_rdata < CELL_EMPTY) begin
                    state_d = ST_OVER;
                end else begin
                    ram.ram_addr  = head_q;
                    ram.ram_we    = 1'b1;
                    ram.ram_wdata = {2'b00, heading_q};
                    grow_d        = (ram.ram_rdata == CELL_FOOD);
                    state_d       = ST_WR_HEAD;
                end
            end
            ST_WR_HEAD: begin
                ram.ram_addr  = head_next;
                ram.ram_we    = 1'b1;
                ram.ram_wdata = HEAD_BASE + {2'b00, heading_q};
                head_d        = head_next;
                if (grow_q) begin
                    if (score_q != 8'hFF) score_d = score_q + 8'd1;
                    state_d = ST_FOOD_RD;
                end else begin
                    state_d = ST_RD_TAIL;
                end
            end
            ST_RD_TAIL: begin
                ram.ram_addr = tail_q;
                state_d      = ST_TAIL_CLR;
            end
            ST_TAIL_CLR: begin
                ram.ram_addr  = tail_q;
                ram.ram_we    = 1'b1;
                ram.ram_wdata = CELL_EMPTY;
                // A well-formed board never points the tail off-grid; hold rather than wrap.
                if (!tail_edge) tail_d = tail_next;
                state_d = ST_IDLE;
            end
            ST_FOOD_RD: begin
                ram.ram_addr = rand_addr;
                food_try_d   = rand_addr;
                state_d      = ST_FOOD_EVAL;
            end
            ST_FOOD_EVAL: begin
                if (ram.ram_rdata == CELL_EMPTY) begin
                    ram.ram_addr  = food_try_q;
                    ram.ram_we    = 1'b1;
                    ram.ram_wdata = CELL_FOOD;
                    state_d       = ST_IDLE;
                end else begin
                    state_d = ST_FOOD_RD;
                end
            end
            ST_OVER: state_d = ST_OVER;
            default: state_d = ST_INIT;
        endcase
    end

    assign busy      = (state_q != ST_IDLE) && (state_q != ST_OVER);
    assign game_over = (state_q == ST_OVER);
    assign score     = score_q;
endmodule

// File: tb/tb_snake_mover.sv
// Bench for snake_mover: behavioural board RAM plus a write scoreboard.
module tb_snake_mover;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       dir_valid = 1'b0;
    logic [1:0] dir_req = 2'd0;
    logic [7:0] rand_addr = 8'd40;
    logic       busy, game_over;
    logic [7:0] score;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];
    logic [11:0] obs_q[$];
    logic [11:0] want, got;

    logic [3:0] mem [256];
    logic       poke_en = 1'b0;
    logic [7:0] poke_addr = '0;
    logic [3:0] poke_data = '0;
    logic [7:0] hd, tl;
    logic [3:0] tc;
    int n;

    snake_mover_if ram_if ();

    snake_mover #(.INIT_HEAD(8'd136), .INIT_TAIL(8'd152), .INIT_DIR(2'd2)) dut (
        .clk(clk), .rst(rst), .tick(tick), .dir_valid(dir_valid), .dir_req(dir_req),
        .rand_addr(rand_addr), .ram(ram_if), .busy(busy), .game_over(game_over), .score(score)
    );

    always #5 clk = ~clk;

    // Board RAM: reset image is head (code 6) at 136, tail (code 0, up) at 152.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= (i == 136) ? 4'd6 : (i == 152) ? 4'd0 : 4'd14;
            ram_if.ram_rdata <= 4'd14;
        end else begin
            if (poke_en) mem[poke_addr] <= poke_data;
            if (ram_if.ram_we) mem[ram_if.ram_addr] <= ram_if.ram_wdata;
            else ram_if.ram_rdata <= mem[ram_if.ram_addr];
        end
    end

    task automatic cyc();
        @(negedge clk);
        if (ram_if.ram_we) obs_q.push_back({ram_if.ram_addr, ram_if.ram_wdata});
    endtask

    task automatic step(output int nb);
        tick = 1'b1; cyc(); tick = 1'b0; nb = 0;
        while (busy && nb < 200) begin nb++; cyc(); end
    endtask

    task automatic test_reset();
        rst = 1'b1; rand_addr = 8'd40;
        cyc(); cyc();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b want 1", busy); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL rst_game_over got %b want 0", game_over); end
        checks++; if (score !== 8'd0) begin errors++; $display("FAIL rst_score got %0d want 0", score); end
        checks++; if (ram_if.ram_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", ram_if.ram_we); end
        checks++; if (ram_if.ram_addr !== 8'd0) begin errors++; $display("FAIL rst_addr got %0d want 0", ram_if.ram_addr); end
        checks++; if (ram_if.ram_wdata !== 4'd14) begin errors++; $display("FAIL rst_wdata got %0d want 14", ram_if.ram_wdata); end
        exp_q.push_back({8'd40, 4'd15});
        rst = 1'b0; n = 0;
        while (busy && n < 50) begin n++; cyc(); end
        checks++; if (n != 3) begin errors++; $display("FAIL rst_busy_len got %0d want 3", n); end
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front(); got = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hFFF;
            checks++; if (got !== want) begin errors++; $display("FAIL reset_write got %0d<=%0d want %0d<=%0d", got[11:4], got[3:0], want[11:4], want[3:0]); end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL reset_extra got %0d writes want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_step();
        exp_q.push_back({8'd136, 4'd2}); exp_q.push_back({8'd135, 4'd6}); exp_q.push_back({8'd152, 4'd14});
        step(n);
        checks++; if (n != 5) begin errors++; $display("FAIL step_busy_len got %0d want 5", n); end
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front(); got = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hFFF;
            checks++; if (got !== want) begin errors++; $display("FAIL step_write got %0d<=%0d want %0d<=%0d", got[11:4], got[3:0], want[11:4], want[3:0]); end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL step_extra got %0d writes want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_reversal();
        dir_valid = 1'b1; dir_req = 2'd3; cyc(); dir_valid = 1'b0;
        // Tail 136 holds code 2 (left), so it advances to 135.
        exp_q.push_back({8'd135, 4'd2}); exp_q.push_back({8'd134, 4'd6}); exp_q.push_back({8'd136, 4'd14});
        step(n);
        checks++; if (n != 5) begin errors++; $display("FAIL rev_busy_len got %0d want 5", n); end
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front(); got = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hFFF;
            checks++; if (got !== want) begin errors++; $display("FAIL rev_write got %0d<=%0d want %0d<=%0d", got[11:4], got[3:0], want[11:4], want[3:0]); end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rev_extra got %0d writes want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_grow();
        poke_en = 1'b1; poke_addr = 8'd133; poke_data = 4'd15; cyc(); poke_en = 1'b0;
        rand_addr = 8'd134;
        exp_q.push_back({8'd134, 4'd2}); exp_q.push_back({8'd133, 4'd6}); exp_q.push_back({8'd50, 4'd15});
        tick = 1'b1; cyc(); tick = 1'b0; n = 0;
        // First food try lands on the fresh body cell; swap in 50 for the retry.
        while (busy && n < 200) begin n++; if (n == 5) rand_addr = 8'd50; cyc(); end
        checks++; if (n != 7) begin errors++; $display("FAIL grow_busy_len got %0d want 7", n); end
        checks++; if (score !== 8'd1) begin errors++; $display("FAIL grow_score got %0d want 1", score); end
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front(); got = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hFFF;
            checks++; if (got !== want) begin errors++; $display("FAIL grow_write got %0d<=%0d want %0d<=%0d", got[11:4], got[3:0], want[11:4], want[3:0]); end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL grow_extra got %0d writes want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_dir_up();
        dir_valid = 1'b1; dir_req = 2'd1; cyc(); dir_req = 2'd0; cyc(); dir_valid = 1'b0;
        exp_q.push_back({8'd133, 4'd0}); exp_q.push_back({8'd117, 4'd4}); exp_q.push_back({8'd135, 4'd14});
        step(n);
        checks++; if (n != 5) begin errors++; $display("FAIL dir_busy_len got %0d want 5", n); end
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front(); got = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hFFF;
            checks++; if (got !== want) begin errors++; $display("FAIL dir_write got %0d<=%0d want %0d<=%0d", got[11:4], got[3:0], want[11:4], want[3:0]); end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL dir_extra got %0d writes want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_collision();
        hd = 8'd117; tl = 8'd134;
        for (int s = 0; s < 7; s++) begin
            tc = mem[tl];
            exp_q.push_back({hd, 4'd0}); exp_q.push_back({hd - 8'd16, 4'd4}); exp_q.push_back({tl, 4'd14});
            case (tc[1:0])
                2'd0: tl = tl - 8'd16;
                2'd1: tl = tl + 8'd16;
                2'd2: tl = tl - 8'd1;
                default: tl = tl + 8'd1;
            endcase
            hd = hd - 8'd16;
            step(n);
            checks++; if (n != 5) begin errors++; $display("FAIL walk_busy_len step %0d got %0d want 5", s, n); end
        end
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front(); got = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hFFF;
            checks++; if (got !== want) begin errors++; $display("FAIL walk_write got %0d<=%0d want %0d<=%0d", got[11:4], got[3:0], want[11:4], want[3:0]); end
        end
        // Head now at row 0 heading up: the next tick leaves the board.
        tick = 1'b1; cyc(); tick = 1'b0;
        cyc();
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL over_early got %b want 0 in cycle 2", game_over); end
        cyc();
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL over_cycle3 got %b want 1", game_over); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL over_busy got %b want 0", busy); end
        tick = 1'b1; cyc(); tick = 1'b0;
        repeat (4) cyc();
        checks++; if (busy !== 1'b0 || game_over !== 1'b1) begin errors++; $display("FAIL over_sticky got busy %b over %b want 0 1", busy, game_over); end
        checks++; if (score !== 8'd1) begin errors++; $display("FAIL over_score got %0d want 1", score); end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL over_writes got %0d writes want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_rst_mid();
        rst = 1'b1; rand_addr = 8'd40; cyc();
        exp_q.push_back({8'd40, 4'd15});
        rst = 1'b0; n = 0;
        while (busy && n < 50) begin n++; cyc(); end
        exp_q.push_back({8'd136, 4'd2});
        tick = 1'b1; cyc(); tick = 1'b0;
        cyc();
        @(negedge clk);
        rst = 1'b1; #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", busy); end
        checks++; if (ram_if.ram_we !== 1'b0) begin errors++; $display("FAIL mid_we got %b want 0", ram_if.ram_we); end
        checks++; if (ram_if.ram_addr !== 8'd0 || ram_if.ram_wdata !== 4'd14) begin errors++; $display("FAIL mid_bus got %0d<=%0d want 0<=14", ram_if.ram_addr, ram_if.ram_wdata); end
        checks++; if (game_over !== 1'b0 || score !== 8'd0) begin errors++; $display("FAIL mid_status got over %b score %0d want 0 0", game_over, score); end
        if (ram_if.ram_we) obs_q.push_back({ram_if.ram_addr, ram_if.ram_wdata});
        cyc();
        exp_q.push_back({8'd40, 4'd15});
        rst = 1'b0; n = 0;
        while (busy && n < 50) begin n++; cyc(); end
        checks++; if (n != 3) begin errors++; $display("FAIL mid_refood_len got %0d want 3", n); end
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front(); got = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hFFF;
            checks++; if (got !== want) begin errors++; $display("FAIL mid_write got %0d<=%0d want %0d<=%0d", got[11:4], got[3:0], want[11:4], want[3:0]); end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL mid_extra got %0d writes want 0", obs_q.size()); obs_q.delete(); end
    endtask

    initial begin
        test_reset();
        test_step();
        test_reversal();
        test_grow();
        test_dir_up();
        test_collision();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
